mem_ddr_mux: RTL



---
 rtl/mem_ddr_mux.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_ddr_mux.sv
// mem_ddr_mux: gathers 256-bit lines striped across SRAM banks into a DDR write beat stream.
// Define MEM_DDR_MUX_PERF_EN to add the stall_cnt output (DDR backpressure cycle counter).
module mem_ddr_mux #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 19,
    parameter int NUM_BANKS  = 16,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_base_addr,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic [4:0]                  cmd_last_bytes,
    output logic [NUM_BANKS-1:0]        sram_read,
    output logic [ADDR_W-1:0]           sram_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_data,
    output logic                        ddr_valid,
    input  logic                        ddr_ready,
    output logic [DATA_W-1:0]           ddr_data,
    output logic                        ddr_last,
    output logic [4:0]                  ddr_bytes,
`ifdef MEM_DDR_MUX_PERF_EN
    output logic [15:0]                 stall_cnt,
`endif
    output logic                        done
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    base_q;
    logic [LEN_W-1:0]     len_q;
    logic [4:0]           last_bytes_q;
    logic [LEN_W:0]       issue_cnt_q, issue_cnt_d;
    logic [NUM_BANKS-1:0] sram_read_q, sram_read_d;
    logic [ADDR_W-1:0]    sram_addr_q, sram_addr_d;
    logic [BW-1:0]        bank_q;
    logic                 tag_last_q;
    logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 done_q, done_d;
    logic                 accept, push, pop, issue, final_issue;
    logic [OW-1:0]        occ;

    // Occupancy credits the beat leaving this cycle so a full-rate stream fits in two entries.
    always_comb begin
        accept      = cmd_valid && cmd_ready;
        pop         = ddr_valid && ddr_ready;
        push        = |sram_read_q;
        occ         = {1'b0, count_q} + OW'(push) - OW'(pop);
        issue       = state_q == RUN && issue_cnt_q <= {1'b0, len_q} && occ < OW'(FIFO_DEPTH);
        final_issue = issue && issue_cnt_q == {1'b0, len_q};
        done_d      = state_q == DRAIN && pop && ddr_last;
        state_d     = accept ? RUN : final_issue ? DRAIN : done_d ? IDLE : state_q;
        issue_cnt_d = accept ? '0 : issue ? issue_cnt_q + 1'b1 : issue_cnt_q;
        sram_read_d = issue ? NUM_BANKS'(1) << issue_cnt_q[BW-1:0] : '0;
        sram_addr_d = issue ? base_q + ADDR_W'(issue_cnt_q >> BW) : sram_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            last_bytes_q <= '0;
            issue_cnt_q  <= '0;
            sram_read_q  <= '0;
            sram_addr_q  <= '0;
            bank_q       <= '0;
            tag_last_q   <= 1'b0;
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            sram_read_q <= sram_read_d;
            sram_addr_q <= sram_addr_d;
            bank_q      <= issue_cnt_q[BW-1:0];
            tag_last_q  <= final_issue;
            done_q      <= done_d;
            count_q     <= count_q + CW'(push) - CW'(pop);
            if (accept) begin
                base_q       <= cmd_base_addr;
                len_q        <= cmd_len;
                last_bytes_q <= cmd_last_bytes;
            end
            if (push) begin
                fifo_data_q[wr_ptr_q] <= sram_data[bank_q*DATA_W +: DATA_W];
                fifo_last_q[wr_ptr_q] <= tag_last_q;
                wr_ptr_q              <= wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        end
    end

`ifdef MEM_DDR_MUX_PERF_EN
    logic [15:0] stall_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n || accept) stall_cnt_q <= '0;
        else if (ddr_valid && !ddr_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
    assign stall_cnt = stall_cnt_q;
`endif

    assign cmd_ready = state_q == IDLE && !done_q;
    assign sram_read = sram_read_q;
    assign sram_addr = sram_addr_q;
    assign ddr_valid = count_q != '0;
    assign ddr_data  = fifo_data_q[rd_ptr_q];
    assign ddr_last  = fifo_last_q[rd_ptr_q];
    assign ddr_bytes = ddr_last ? last_bytes_q : 5'd0;
    assign done      = done_q;
endmodule
